// File: rtl/h264_nc_pkg.sv
// h264_nc_pkg: shared types, constants and nC averaging helper for the CAVLC context store
package h264_nc_pkg;
  typedef enum logic [1:0] {LUMA, CB, CR, CDC} comp_t;
  localparam int TCBITS_DEF = 5;
  localparam logic [5:0] NC_DC = 6'h3F;
  function automatic logic [5:0] nc_avg(input logic [7:0] a, input logic [7:0] b,
                                        input logic avail_a, input logic avail_b);
    return (avail_a && avail_b) ? 6'((9'(a) + 9'(b) + 9'd1) >> 1) :
           avail_a ? 6'(a) : avail_b ? 6'(b) : 6'd0;
  endfunction
endpackage

// File: rtl/h264_nc_context_topram.sv
// h264_nc_topram: simple dual-port RAM with synchronous read holding the above-row context
module h264_nc_topram #(
  parameter int DEPTH = 22,
  parameter int AW = 5,
  parameter int DW = 40
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/h264_nc_context.sv
// h264_nc_context: neighbour TotalCoeff store and nC calculator for coeff_token table select
module h264_nc_context import h264_nc_pkg::*; #(
  parameter int IMGWIDTH = 352,
  parameter int MBW = IMGWIDTH / 16,
  parameter int MBWBITS = 5,
  parameter int TCBITS = TCBITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              newslice,
  input  logic              newline,
  input  logic              mb_next,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [1:0]        q_comp,
  input  logic [3:0]        q_blk,
  output logic              r_valid,
  output logic [5:0]        r_nc,
  input  logic              w_valid,
  input  logic [1:0]        w_comp,
  input  logic [3:0]        w_blk,
  input  logic [TCBITS-1:0] w_tc
);
  logic [TCBITS-1:0] cur_l [16], cur_cb [4], cur_cr [4];
  logic [TCBITS-1:0] nx_l [16], nx_cb [4], nx_cr [4];
  logic [TCBITS-1:0] left_l [4], left_cb [2], left_cr [2];
  logic [MBWBITS-1:0] mbx;
  logic left_avail, top_avail, row_seen, acc, is_cr;
  logic [8*TCBITS-1:0] top_w, top_r;
  logic [TCBITS-1:0] a_n, b_n, a_q, b_q, b_eff;
  logic a_av_n, b_cur_n, a_av_q, b_av_q, b_top_q, dc_q;
  logic [2:0] fsel_n, fsel_q;
  logic [1:0] lbx, lby, c;
  logic cbx, cby;
  assign q_ready = ~(mb_next | newline | newslice);
  assign acc = q_valid & q_ready;
  assign is_cr = q_comp == CR;
  assign lbx = q_blk[1:0];
  assign lby = q_blk[3:2];
  assign c = q_blk[1:0];
  assign cbx = q_blk[0];
  assign cby = q_blk[1];
  assign top_w = {nx_cr[3], nx_cr[2], nx_cb[3], nx_cb[2], nx_l[15], nx_l[14], nx_l[13], nx_l[12]};
  // current-MB values with any same-cycle write applied, used by both lookup and commit
  always_comb begin
    nx_l = cur_l;
    nx_cb = cur_cb;
    nx_cr = cur_cr;
    if (w_valid && w_comp == LUMA) nx_l[w_blk] = w_tc;
    if (w_valid && w_comp == CB) nx_cb[w_blk[1:0]] = w_tc;
    if (w_valid && w_comp == CR) nx_cr[w_blk[1:0]] = w_tc;
  end
  // neighbour A/B selection; an above-row B is resolved from the RAM one cycle later
  always_comb begin
    if (q_comp == LUMA) begin
      a_n = lbx != 2'd0 ? nx_l[q_blk - 4'd1] : left_l[lby];
      a_av_n = lbx != 2'd0 || left_avail;
      b_n = lby != 2'd0 ? nx_l[q_blk - 4'd4] : '0;
      b_cur_n = lby != 2'd0;
      fsel_n = {1'b0, lbx};
    end else begin
      a_n = cbx ? (is_cr ? nx_cr[c - 2'd1] : nx_cb[c - 2'd1]) : (is_cr ? left_cr[cby] : left_cb[cby]);
      a_av_n = cbx || left_avail;
      b_n = cby ? (is_cr ? nx_cr[c - 2'd2] : nx_cb[c - 2'd2]) : '0;
      b_cur_n = cby;
      fsel_n = {1'b1, is_cr, cbx};
    end
  end
  // capture the accepted query so the response completes even across newslice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      dc_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      a_av_q <= 1'b0;
      b_av_q <= 1'b0;
      b_top_q <= 1'b0;
      fsel_q <= '0;
    end else begin
      r_valid <= acc;
      if (acc) begin
        dc_q <= q_comp == CDC;
        a_q <= a_n;
        a_av_q <= a_av_n;
        b_q <= b_n;
        b_av_q <= b_cur_n | top_avail;
        b_top_q <= ~b_cur_n;
        fsel_q <= fsel_n;
      end
    end
  end
  assign b_eff = b_top_q ? top_r[fsel_q*TCBITS +: TCBITS] : b_q;
  assign r_nc = dc_q ? NC_DC : nc_avg(8'(a_q), 8'(b_eff), a_av_q, b_av_q);
  // context state: writes, commit on mb_next, row and slice boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_l <= '{default: '0};
      cur_cb <= '{default: '0};
      cur_cr <= '{default: '0};
      left_l <= '{default: '0};
      left_cb <= '{default: '0};
      left_cr <= '{default: '0};
      mbx <= '0;
      left_avail <= 1'b0;
      top_avail <= 1'b0;
      row_seen <= 1'b0;
    end else if (newslice) begin
      cur_l <= '{default: '0};
      cur_cb <= '{default: '0};
      cur_cr <= '{default: '0};
      mbx <= '0;
      left_avail <= 1'b0;
      top_avail <= 1'b0;
      row_seen <= 1'b0;
    end else begin
      if (mb_next) begin
        for (int i = 0; i < 4; i++) left_l[i] <= nx_l[4*i+3];
        for (int i = 0; i < 2; i++) left_cb[i] <= nx_cb[2*i+1];
        for (int i = 0; i < 2; i++) left_cr[i] <= nx_cr[2*i+1];
        cur_l <= '{default: '0};
        cur_cb <= '{default: '0};
        cur_cr <= '{default: '0};
        left_avail <= 1'b1;
        row_seen <= 1'b1;
        mbx <= mbx == MBWBITS'(MBW - 1) ? '0 : mbx + 1'b1;
      end else begin
        cur_l <= nx_l;
        cur_cb <= nx_cb;
        cur_cr <= nx_cr;
      end
      if (newline) begin
        mbx <= '0;
        left_avail <= 1'b0;
        top_avail <= row_seen | mb_next;
      end
    end
  end
  h264_nc_topram #(.DEPTH(MBW), .AW(MBWBITS), .DW(8*TCBITS)) u_topram (
    .clk(clk),
    .we(mb_next),
    .waddr(mbx),
    .wdata(top_w),
    .re(acc),
    .raddr(mbx),
    .rdata(top_r)
  );
endmodule

// File: doc/h264_nc_context.md
Name: h264_nc_context

Overview:
- Parametrised neighbour-context store and nC calculator for the CAVLC coeff_token table select.
- Generalises the ad-hoc left/top TotalCoeff arrays and their averaging in the encoder top. Adds:
  - full per-macroblock luma + 4:2:0 chroma (Cb/Cr) context;
  - slice/line availability masking;
  - chroma-DC nC = -1;
  - a valid/ready query interface with registered response.
- Sits between h264buffer (issues queries and writes) and h264cavlc (consumes nC).

Parameters:
- IMGWIDTH, 352, picture width in pixels; multiple of 16.
- MBW, IMGWIDTH/16, macroblocks per row; depth of the top-context RAM.
- MBWBITS, 5, width of the MB column counter; must satisfy 2**MBWBITS >= MBW.
- TCBITS, 5, TotalCoeff width (0..16).

Ports:
- clk       in   1          clock; all logic on rising edge.
- rst_n     in   1          asynchronous, active-low reset.
- newslice  in   1          start of slice; clears availability and counters.
- newline   in   1          start of MB row.
- mb_next   in   1          current MB complete; commit context, advance column.
- q_valid   in   1          nC query request.
- q_ready   out  1          query accepted when q_valid & q_ready.
- q_comp    in   2          0 luma, 1 Cb AC, 2 Cr AC, 3 chroma DC.
- q_blk     in   4          raster 4x4 index. Luma: bx=q_blk[1:0], by=q_blk[3:2]. Chroma: bx=q_blk[0], by=q_blk[1].
- r_valid   out  1          one-cycle strobe, response valid.
- r_nc      out  6          signed nC (-1..16).
- w_valid   in   1          store TotalCoeff for a block of the current MB.
- w_comp    in   2          component of write (0/1/2; value 3 is ignored).
- w_blk     in   4          raster index of write.
- w_tc      in   TCBITS     TotalCoeff value.

Behaviour:
Reset (rst_n low, asynchronous):
- q_ready=1, r_valid=0, r_nc=0.
- mbx=0, left_avail=0, top_avail=0, row_seen=0.
- Current-MB registers cleared. Top RAM contents are don't-care (masked by top_avail).

State:
- Current-MB registers: cur_l[16], cur_cb[4], cur_cr[4], each TCBITS.
- Left registers: left_l[4] (col 3 of previous MB), left_cb[2], left_cr[2].
- Top RAM: MBW words of 8*TCBITS. Packs luma row 3 (4), Cb row 1 (2), Cr row 1 (2).
- One read port, one write port, synchronous read.

Query:
- Accepted in cycle T. Top RAM word at mbx is read in T.
- In T+1, r_valid=1 and r_nc is driven from a combinational calculation registered at the T+1 edge, so latency is exactly 1 cycle.
- Current-MB registers are sampled in T after any same-cycle w_valid update, so write-then-query in the same cycle forwards the new value.
- Neighbour A (left):
  - bx>0: cur[blk-1].
  - bx==0: left register for row `by`, available only if left_avail.
- Neighbour B (above):
  - by>0: cur[blk-row].
  - by==0: top RAM field for `bx`, available only if top_avail.
- nC:
  - both available: (A+B+1)>>1, computed in TCBITS+1 bits;
  - one available: that value;
  - neither: 0.
- q_comp==3: r_nc=-1 (6'h3F), no lookup, same 1-cycle latency.
- Back-to-back queries allowed every cycle.
- q_ready=0 only in a cycle where mb_next, newline or newslice is high; queries are not accepted in that cycle.

Commit (mb_next):
- Single cycle: top RAM[mbx] <= bottom rows; left regs <= right columns; current regs cleared; left_avail=1; row_seen=1.
- mbx <= mbx+1, wrapping MBW-1 -> 0.

newline:
- mbx=0, left_avail=0, top_avail=row_seen.
- If mb_next is high in the same cycle, the commit is applied first, then newline.

newslice:
- Dominates everything: mbx=0, left_avail=0, top_avail=0, row_seen=0, current regs cleared.
- A response in flight still completes, using pre-slice values.

Other rules:
- w_valid in the same cycle as mb_next writes the old MB before commit, i.e. the write is included in the commit.
- w_tc > 16 is stored truncated to TCBITS; the caller must not send it.

Decomposition:
- Package h264_nc_pkg:
  - comp_t enum (LUMA, CB, CR, CDC);
  - NC_DC = -1;
  - TCBITS default;
  - function nc_avg(a, b, avail_a, avail_b).
- One sub-module: h264_nc_topram, a simple dual-port synchronous RAM (MBW x 8*TCBITS) for inference.

Test Plan:
1. After reset and newslice, query luma blk 0 -> r_valid at T+1 with r_nc=0 (nothing available).
2. Write luma blk 0 tc=5, then query blk 1 -> r_nc=5 (A only). Write blk 1 tc=2, query blk 5 -> r_nc=(2+1)>>1... B=cur[1]=2, A=cur[4]=0, so r_nc=(0+2+1)>>1=1.
3. MB0 with right column tc=7, mb_next; query luma blk 0 of MB1 -> r_nc=7 (left only, first row).
4. Complete row 0 with column 0 bottom-row tc=4, newline; query blk 0 -> r_nc=4. Then newslice, same query -> r_nc=0.
5. Query q_comp=3 -> r_nc=6'h3F. Query Cb blk 3 with cur_cb[1]=3, cur_cb[2]=6 -> r_nc=5.
6. Assert rst_n low mid-response -> r_valid=0 immediately (asynchronous). Assert mb_next and q_valid together -> q_ready=0, no response; mbx wraps after MBW commits.
